// File: rtl/multi_freq_gen.sv
// multi_freq_gen: per-channel clock divider with toggle, tick and PWM modes.
// Optional FREQ_GEN_SYNC_EN adds a sync input that phase-aligns all channels.
module multi_freq_gen #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 28
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] enable,
   input  logic [CHANNELS-1:0] load,
   input  logic [WIDTH-1:0]    limit_in,
   input  logic [WIDTH-1:0]    duty_in,
   input  logic [1:0]          mode_in,
`ifdef FREQ_GEN_SYNC_EN
   input  logic                sync,
`endif
   output logic [CHANNELS-1:0] wave_out,
   output logic [CHANNELS-1:0] tick_out,
   output logic [CHANNELS-1:0] pending
);

   typedef enum logic [1:0] {
      M_TOGGLE = 2'b00,
      M_TICK   = 2'b01,
      M_PWM    = 2'b10
   } kind_t;

   // code 11 behaves as toggle
   function automatic kind_t kind(input logic [1:0] m);
      kind_t k;
      k = M_TOGGLE;
      if (m == 2'b01) k = M_TICK;
      if (m == 2'b10) k = M_PWM;
      return k;
   endfunction

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] count, count_n;
      logic [WIDTH-1:0] lim_a, lim_s, lim_n;
      logic [WIDTH-1:0] duty_a, duty_s, duty_n;
      kind_t            mode_a, mode_s, mode_n;
      logic             pend, pend_n;
      logic             wave, wave_n;
      logic             tick;
      logic             bnd, sy, bypass, apply, chg;

`ifdef FREQ_GEN_SYNC_EN
      assign sy = sync & enable[i];
`else
      assign sy = 1'b0;
`endif

      // boundary detection, config hand-over and next output values
      always_comb begin
         bnd    = enable[i] && (count == lim_a);
         bypass = load[i] && (bnd || sy);
         apply  = bypass || (pend && (!enable[i] || bnd || sy));
         lim_n  = lim_a;
         duty_n = duty_a;
         mode_n = mode_a;
         if (bypass) begin
            lim_n  = limit_in;
            duty_n = duty_in;
            mode_n = kind(mode_in);
         end else if (apply) begin
            lim_n  = lim_s;
            duty_n = duty_s;
            mode_n = mode_s;
         end
         chg = (mode_n != mode_a);
         if (bypass)       pend_n = 1'b0;
         else if (load[i]) pend_n = 1'b1;
         else if (apply)   pend_n = 1'b0;
         else              pend_n = pend;
         if (!enable[i] || sy || bnd) count_n = '0;
         else                         count_n = count + 1'b1;
         wave_n = 1'b0;
         if (enable[i] && !sy) begin
            case (mode_n)
               M_TICK:  wave_n = bnd;
               M_PWM:   wave_n = (count_n < duty_n);
               default: wave_n = chg ? 1'b0 : (wave ^ bnd);
            endcase
         end
      end

      // channel state registers
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            count  <= '0;
            lim_a  <= '0;
            duty_a <= '0;
            mode_a <= M_TOGGLE;
            lim_s  <= '0;
            duty_s <= '0;
            mode_s <= M_TOGGLE;
            pend   <= 1'b0;
            wave   <= 1'b0;
            tick   <= 1'b0;
         end else begin
            count  <= count_n;
            lim_a  <= lim_n;
            duty_a <= duty_n;
            mode_a <= mode_n;
            pend   <= pend_n;
            wave   <= wave_n;
            tick   <= bnd && !sy;
            if (load[i]) begin
               lim_s  <= limit_in;
               duty_s <= duty_in;
               mode_s <= kind(mode_in);
            end
         end
      end

      assign wave_out[i] = wave;
      assign tick_out[i] = tick;
      assign pending[i]  = pend;
   end

endmodule

// File: tb/tb_multi_freq_gen.sv
// tb_multi_freq_gen: random and directed stimulus against a period-level model.
module tb_multi_freq_gen;
   localparam int CH = 4;
   localparam int W  = 28;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CH-1:0] en = '0;
   logic [CH-1:0] ld = '0;
   logic [W-1:0]  lim_i = '0;
   logic [W-1:0]  duty_i = '0;
   logic [1:0]    mode_i = '0;
   logic [CH-1:0] wave, tick, pend;
`ifdef FREQ_GEN_SYNC_EN
   logic          sync = 1'b0;
`endif

   multi_freq_gen #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clock(clk),
      .reset_n(rst_n),
      .enable(en),
      .load(ld),
      .limit_in(lim_i),
      .duty_in(duty_i),
      .mode_in(mode_i),
`ifdef FREQ_GEN_SYNC_EN
      .sync(sync),
`endif
      .wave_out(wave),
      .tick_out(tick),
      .pending(pend)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   // reference: position in period, active/shadow config, periods since start
   int pos[CH], alim[CH], aduty[CH], amode[CH];
   int slim[CH], sduty[CH], smode[CH], nper[CH];
   bit mpend[CH], ew[CH], et[CH];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int kind(input int m);
      return (m == 1) ? 1 : (m == 2) ? 2 : 0;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         pos[c] = 0; alim[c] = 0; aduty[c] = 0; amode[c] = 0;
         slim[c] = 0; sduty[c] = 0; smode[c] = 0; nper[c] = 0;
         mpend[c] = 0; ew[c] = 0; et[c] = 0;
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < CH; c++) begin
         if (!en[c]) begin
            pos[c] = 0; nper[c] = 0; ew[c] = 0; et[c] = 0;
            if (mpend[c]) begin
               alim[c] = slim[c]; aduty[c] = sduty[c];
               amode[c] = smode[c]; mpend[c] = 0;
            end
            if (ld[c]) begin
               slim[c] = int'(lim_i); sduty[c] = int'(duty_i);
               smode[c] = kind(int'(mode_i)); mpend[c] = 1;
            end
         end else begin
            bit endp, chg;
            endp = (pos[c] == alim[c]);
            et[c] = endp;
            chg = 0;
            if (endp) begin
               if (ld[c]) begin
                  chg = kind(int'(mode_i)) != amode[c];
                  alim[c] = int'(lim_i); aduty[c] = int'(duty_i);
                  amode[c] = kind(int'(mode_i)); mpend[c] = 0;
               end else if (mpend[c]) begin
                  chg = smode[c] != amode[c];
                  alim[c] = slim[c]; aduty[c] = sduty[c];
                  amode[c] = smode[c]; mpend[c] = 0;
               end
               nper[c] = chg ? 0 : nper[c] + 1;
               pos[c] = 0;
            end else begin
               if (ld[c]) begin
                  slim[c] = int'(lim_i); sduty[c] = int'(duty_i);
                  smode[c] = kind(int'(mode_i)); mpend[c] = 1;
               end
               pos[c]++;
            end
            case (amode[c])
               1:       ew[c] = endp;
               2:       ew[c] = pos[c] < aduty[c];
               default: ew[c] = nper[c][0];
            endcase
         end
      end
   endtask

   task automatic compare_all();
      for (int c = 0; c < CH; c++) begin
         check($sformatf("wave%0d", c), 32'(wave[c]), 32'(ew[c]));
         check($sformatf("tick%0d", c), 32'(tick[c]), 32'(et[c]));
         check($sformatf("pend%0d", c), 32'(pend[c]), 32'(mpend[c]));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      ld = '0;
   endtask

   task automatic cfg(input int c, input int l, input int d, input int m);
      ld = '0;
      ld[c] = 1'b1;
      lim_i = W'(l);
      duty_i = W'(d);
      mode_i = 2'(m);
   endtask

   int hi, tk, guard;

   initial begin
      model_reset();
      #2;
      check("reset_wave", 32'(wave), 0);
      check("reset_tick", 32'(tick), 0);
      check("reset_pend", 32'(pend), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // run ch0 limit 3 toggle, then async reset between edges
      cfg(0, 3, 0, 0); cycle();
      en[0] = 1'b1;
      repeat (8) cycle();
      cfg(1, 5, 0, 0);
      #2;
      rst_n = 1'b0;
      ld = '0;
      #1;
      model_reset();
      check("async_wave", 32'(wave), 0);
      check("async_tick", 32'(tick), 0);
      check("async_pend", 32'(pend), 0);
      #2;
      rst_n = 1'b1;
      en = '0;
      cycle();

      // toggle limit 4: 10-clock period, 5 high, ticks every 5
      cfg(0, 4, 0, 0); cycle();
      en[0] = 1'b1;
      repeat (12) cycle();
      hi = 0; tk = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         hi += int'(wave[0]);
         tk += int'(tick[0]);
      end
      check("toggle_high", 32'(hi), 5);
      check("toggle_ticks", 32'(tk), 2);

      // PWM limit 9 duty 3, updated mid-period to limit 3 duty 2
      cfg(1, 9, 3, 2); cycle();
      en[1] = 1'b1;
      repeat (13) cycle();
      cfg(1, 3, 2, 2); cycle();
      check("upd_pending", 32'(pend[1]), 1);
      repeat (12) cycle();
      hi = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         hi += int'(wave[1]);
      end
      check("upd_high", 32'(hi), 4);

      // PWM duty 0 and duty above period
      cfg(2, 5, 0, 2); cycle();
      cfg(3, 7, 8, 2); cycle();
      en[2] = 1'b1; en[3] = 1'b1;
      hi = 0; tk = 0;
      repeat (24) begin
         cycle();
         hi += int'(wave[2]);
         tk += int'(wave[3]);
      end
      check("pwm_duty0", 32'(hi), 0);
      check("pwm_full", 32'(tk), 24);

      // load on the boundary cycle bypasses pending
      guard = 0;
      while (pos[0] != alim[0] && guard < 40) begin
         cycle();
         guard++;
      end
      check("bnd_found", 32'(guard < 40), 1);
      cfg(0, 2, 1, 2); cycle();
      check("bnd_pend", 32'(pend[0]), 0);
      repeat (10) cycle();

      // randomized traffic
      repeat (600) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
            ld[c] = ($urandom_range(0, 7) == 0);
         end
         lim_i = W'($urandom_range(0, 6));
         duty_i = W'($urandom_range(0, 8));
         mode_i = 2'($urandom_range(0, 3));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/multi_freq_gen.md
# multi_freq_gen

Parametrised multi-channel frequency generator: each channel divides the system clock by a programmable period and drives a square wave, a single-cycle tick train or a PWM waveform. Period, duty and mode are written at any time and applied glitch-free at the next period boundary. The block serves as the shared timing source for display refresh, debouncing, audio tones and LED dimming, and replaces per-use single-limit toggle dividers.

## Interface
- CHANNELS, 4, number of independent channels (1..16)
- WIDTH, 28, width of period/duty counters and values
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- enable  input  CHANNELS  per-channel run enable, level-sensitive
- load  input  CHANNELS  per-channel configuration write strobe
- limit_in  input  WIDTH  period terminal count, shared by all channels; period = limit_in+1 clocks
- duty_in  input  WIDTH  PWM high time in clocks, shared
- mode_in  input  2  00 toggle, 01 tick, 10 PWM, 11 treated as toggle
- wave_out  output  CHANNELS  generated waveform, registered
- tick_out  output  CHANNELS  one-clock pulse at each period end, registered
- pending  output  CHANNELS  high while a loaded configuration awaits its period boundary

## Operation
- Per channel: counter `count` [WIDTH], active regs (limit, duty, mode), shadow regs (limit, duty, mode), pending flag.
- load[i] high: shadow[i] <= {limit_in, duty_in, mode_in}, pending[i] <= 1. Multiple loads before a boundary: last wins.
- Boundary for channel i: enable[i] high and count == active limit. Transfer shadow → active when pending, pending <= 0. Channel disabled: transfer happens on the next edge where pending is 1 (idle channels apply immediately).
- load and boundary in the same cycle: incoming limit_in/duty_in/mode_in bypass straight into active; pending stays 0.
- Counting while enabled: count <= (count == limit) ? 0 : count+1. Counter is compared against the active limit only.
- tick_out[i] <= enable[i] && count == limit (all modes).
- Toggle mode: wave_out toggles at each boundary; output frequency f_clk / (2·(limit+1)); limit 0 toggles every clock.
- Tick mode: wave_out equals tick_out.
- PWM mode: wave_out <= (next count < duty); duty 0 → constant low; duty ≥ limit+1 → constant high.
- A mode change applied at a boundary clears wave_out to 0 before the new mode evaluates (toggle restarts from low).
- enable[i] low: count <= 0, wave_out[i] <= 0, tick_out[i] <= 0; configuration state is retained.
- Channels are fully independent; the shared input buses are sampled only by channels whose load bit is set.

## Timing
- Reset (reset_n low, asynchronous): count 0, wave_out 0, tick_out 0, pending 0, active and shadow limit 0, duty 0, mode 00. Release is synchronous to the first clock edge.
- enable rising: the first edge with enable high increments count to 1 (or wraps if limit 0). The first tick_out is high in the cycle after edge limit+1.
- load → pending high on the next edge. Applied at the end of the current period, at worst limit+1 clocks later.
- Toggle/tick/PWM outputs are registered, with no combinational path from input to output.
- enable deasserted mid-period: outputs low on the next edge, and the partial period is discarded.

## Configuration
- FREQ_GEN_SYNC_EN defined: adds input `sync` (1 bit). When sync is high on an edge, every enabled channel forces count to 0, forces wave_out to 0 and applies any pending configuration, and tick_out is not asserted that cycle. Used to phase-align channels.
- Not defined: the `sync` port and its logic are absent, and channels run free-phase.

## Test plan
- Reset mid-run: channel 0 running limit 3 toggle, pull reset_n low between edges → all outputs 0 immediately, pending 0.
- Toggle: load limit 4, mode 00, enable → wave_out period 10 clocks, 5 high / 5 low, tick every 5 clocks.
- Glitch-free update: running limit 9 PWM duty 3, load limit 3 duty 2 mid-period → pending high, current period completes 10 clocks with 3 high, then 4-clock periods with 2 high, pending low.
- PWM edges: duty 0 → wave_out constant 0; duty 8 with limit 7 → constant 1; tick_out still every 8 clocks.
- Simultaneous load at boundary: load asserted on the cycle count == limit → new limit active on the following period, pending never observed high.
- With FREQ_GEN_SYNC_EN: channels at limit 2 and limit 5 offset, pulse sync → both counters 0 on the same edge, next ticks at 3 and 6 clocks later.
